// File: rtl/cme_ip_syn_fifo_v3.sv
`default_nettype none
// ============================================================================
//  Module   : cme_ip_syn_fifo_v3
//  Function : Single-clock first-word-fall-through FIFO with synchronous-read
//             storage, any depth (non-power-of-two allowed), programmable
//             almost-full/almost-empty flags and optional packet mode.
//             Optional feature macro: SYN_FIFO_PKT_EN (adds wr_commit,
//             wr_drop and pkt_cnt; written words stay hidden until committed).
//  Revision : v3.0 - initial release
// ============================================================================
module cme_ip_syn_fifo_v3 #(
  parameter  int DW        = 16,
  parameter  int DEPTH     = 1024,
  parameter  int AF_THRESH = DEPTH - 4,
  parameter  int AE_THRESH = 4,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wen,
  input  logic [DW-1:0] wdata,
  output logic          wfull,
  output logic          wr_ack,
  output logic          overflow,
  input  logic          ren,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          underflow,
  output logic [CW-1:0] count,
  output logic          af,
  output logic          ae
`ifdef SYN_FIFO_PKT_EN
  ,
  input  logic          wr_commit,
  input  logic          wr_drop,
  output logic [CW-1:0] pkt_cnt
`endif
);

  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  // Pointers wrap by explicit compare so any depth works.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + AW'(1);
  endfunction

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] vis_q, vis_d;     // committed words not yet popped
  logic [CW-1:0] occ_d;            // all written words not yet popped
  logic [DW-1:0] s1_data_q;        // read-pipeline stage between array and output
  logic          s1_vld_q;
  logic [DW-1:0] rdata_q;
  logic          rvalid_q;
  logic          wfull_q, af_q, ae_q;
  logic          wr_ack_q, overflow_q, underflow_q;

  logic          clear;
  logic          wr_acc, pop;
  logic          out_free, mv, s1_free, mem_avail, issue;
  logic [CW-1:0] pipe_cnt;

`ifdef SYN_FIFO_PKT_EN
  logic [AW-1:0] cptr_q, cptr_d;   // boundary between uncommitted and visible words
  logic [CW-1:0] pend_q, pend_d;   // uncommitted words
`endif

  assign clear = rst | clr;
  // wfull is the registered value, so a full FIFO rejects even with a same-cycle pop.
  assign wr_acc = wen & ~wfull_q & ~clear;
  assign pop    = ren & rvalid_q & ~clear;

  // Read pipeline: array -> stage 1 -> output register, refilled every cycle.
  always_comb begin
    out_free  = ~rvalid_q | pop;
    mv        = s1_vld_q & out_free;
    s1_free   = ~s1_vld_q | mv;
    pipe_cnt  = CW'(s1_vld_q) + CW'(rvalid_q);
    mem_avail = vis_q > pipe_cnt;
    issue     = mem_avail & s1_free & ~clear;
  end

`ifdef SYN_FIFO_PKT_EN
  // Next-state occupancy with commit/drop; drop wins over commit.
  always_comb begin
    wptr_d = wr_acc ? ptr_inc(wptr_q) : wptr_q;
    cptr_d = cptr_q;
    pend_d = pend_q + CW'(wr_acc);
    vis_d  = vis_q - CW'(pop);
    if (wr_drop) begin
      wptr_d = cptr_q;
      pend_d = '0;
    end else if (wr_commit) begin
      cptr_d = wptr_d;
      vis_d  = vis_q + pend_q + CW'(wr_acc) - CW'(pop);
      pend_d = '0;
    end
    occ_d = vis_d + pend_d;
  end
`else
  // Next-state occupancy; every accepted word is visible at once.
  always_comb begin
    wptr_d = wr_acc ? ptr_inc(wptr_q) : wptr_q;
    vis_d  = vis_q + CW'(wr_acc) - CW'(pop);
    occ_d  = vis_d;
  end
`endif

  // Storage array with synchronous read into the pipeline stage (no reset needed).
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q] <= wdata;
    if (issue)  s1_data_q     <= mem_q[rptr_q];
  end

  // Control state, flags and pulses.
  always_ff @(posedge clk) begin
    if (clear) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      vis_q       <= '0;
      s1_vld_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      wfull_q     <= 1'b0;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      if (issue) rptr_q <= ptr_inc(rptr_q);
      vis_q       <= vis_d;
      s1_vld_q    <= issue | (s1_vld_q & ~mv);
      rvalid_q    <= mv | (rvalid_q & ~pop);
      if (mv) rdata_q <= s1_data_q;
      wfull_q     <= (occ_d == CW'(DEPTH));
      af_q        <= (occ_d >= CW'(AF_THRESH));
      ae_q        <= (vis_d <= CW'(AE_THRESH));
      wr_ack_q    <= wr_acc;
      overflow_q  <= wen & wfull_q;
      underflow_q <= ren & ~rvalid_q;
    end
  end

`ifdef SYN_FIFO_PKT_EN
  // Packet bookkeeping.
  always_ff @(posedge clk) begin
    if (clear) begin
      cptr_q <= '0;
      pend_q <= '0;
    end else begin
      cptr_q <= cptr_d;
      pend_q <= pend_d;
    end
  end

  assign pkt_cnt = pend_q;
`endif

  assign wfull     = wfull_q;
  assign wr_ack    = wr_ack_q;
  assign overflow  = overflow_q;
  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign underflow = underflow_q;
  assign count     = vis_q;
  assign af        = af_q;
  assign ae        = ae_q;

endmodule
`default_nettype wire

// File: tb/tb_cme_ip_syn_fifo_v3.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cme_ip_syn_fifo_v3
//  Function : Directed self-checking bench for cme_ip_syn_fifo_v3 (DEPTH=6)
//             with a data scoreboard and an occupancy model.
//             Packet tests compile when SYN_FIFO_PKT_EN is defined.
//  Revision : v3.0 - initial release
// ============================================================================
module tb_cme_ip_syn_fifo_v3;

  localparam int DW    = 16;
  localparam int DEPTH = 6;
  localparam int AFT   = 5;
  localparam int AET   = 2;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef SYN_FIFO_PKT_EN
  localparam bit PKT = 1'b1;
`else
  localparam bit PKT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, clr, wen, ren, wr_commit, wr_drop;
  logic [DW-1:0] wdata;
  logic          wfull, wr_ack, overflow, rvalid, underflow, af, ae;
  logic [DW-1:0] rdata;
  logic [CW-1:0] count;
`ifdef SYN_FIFO_PKT_EN
  logic [CW-1:0] pkt_cnt;
`endif

  int            errs   = 0;
  int            checks = 0;
  int            vis_m  = 0;
  int            pend_m = 0;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] pq[$];

  cme_ip_syn_fifo_v3 #(
    .DW(DW), .DEPTH(DEPTH), .AF_THRESH(AFT), .AE_THRESH(AET)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .wen(wen), .wdata(wdata),
    .wfull(wfull), .wr_ack(wr_ack), .overflow(overflow),
    .ren(ren), .rdata(rdata), .rvalid(rvalid), .underflow(underflow),
    .count(count), .af(af), .ae(ae)
`ifdef SYN_FIFO_PKT_EN
    , .wr_commit(wr_commit), .wr_drop(wr_drop), .pkt_cnt(pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, score pops before the edge, check after it.
  task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r,
                     input bit cm, input bit dr);
    bit            full, acc, pp, ovf, unf;
    logic [DW-1:0] e;
    wen = w; wdata = d; ren = r; wr_commit = cm; wr_drop = dr;
    #1;
    pp = r && (rvalid === 1'b1);
    if (pp) begin
      checks++;
      assert (sb.size() > 0) else begin
        errs++;
        $error("FAIL sb_underrun observed=pop expected=no_word");
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rdata", 32'(rdata), 32'(e));
      end
    end
    full = (vis_m + pend_m) == DEPTH;
    acc  = w && !full;
    ovf  = w && full;
    unf  = r && !(rvalid === 1'b1);
    if (PKT && dr) begin
      pq.delete();
      pend_m = 0;
    end else begin
      if (acc) begin
        pq.push_back(d);
        pend_m++;
      end
      if (!PKT || cm) begin
        foreach (pq[i]) sb.push_back(pq[i]);
        vis_m += pend_m;
        pend_m = 0;
        pq.delete();
      end
    end
    if (pp) vis_m--;
    @(posedge clk);
    @(negedge clk);
    chk("wr_ack",    32'(wr_ack),    32'(acc));
    chk("overflow",  32'(overflow),  32'(ovf));
    chk("underflow", 32'(underflow), 32'(unf));
    chk("count",     32'(count),     32'(vis_m));
    chk("wfull",     32'(wfull),     32'((vis_m + pend_m) == DEPTH));
    chk("af",        32'(af),        32'((vis_m + pend_m) >= AFT));
    chk("ae",        32'(ae),        32'(vis_m <= AET));
`ifdef SYN_FIFO_PKT_EN
    chk("pkt_cnt",   32'(pkt_cnt),   32'(pend_m));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rst_clr(input bit use_rst, input bit w, input bit r);
    rst = use_rst; clr = !use_rst; wen = w; wdata = 16'hDEAD; ren = r;
    wr_commit = 1'b0; wr_drop = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; clr = 1'b0; wen = 1'b0; ren = 1'b0;
    vis_m = 0; pend_m = 0; sb.delete(); pq.delete();
    chk("clr_count",    32'(count),     32'd0);
    chk("clr_rvalid",   32'(rvalid),    32'd0);
    chk("clr_wfull",    32'(wfull),     32'd0);
    chk("clr_af",       32'(af),        32'd0);
    chk("clr_ae",       32'(ae),        32'd1);
    chk("clr_wr_ack",   32'(wr_ack),    32'd0);
    chk("clr_overflow", 32'(overflow),  32'd0);
    chk("clr_underflw", 32'(underflow), 32'd0);
    if (use_rst) chk("rst_rdata", 32'(rdata), 32'd0);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; wen = 1'b0; ren = 1'b0; wdata = '0;
    wr_commit = 1'b0; wr_drop = 1'b0;
    rst_clr(1'b1, 1'b1, 1'b1);

    // FWFT latency from empty: visible after the second edge.
    cyc(1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b0);
    chk("lat_e0_rvalid", 32'(rvalid), 32'd0);
    idle(1);
    chk("lat_e1_rvalid", 32'(rvalid), 32'd0);
    idle(1);
    chk("lat_e2_rvalid", 32'(rvalid), 32'd1);
    chk("lat_e2_rdata",  32'(rdata),  32'hA5A5);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("lat_pop_rvalid", 32'(rvalid), 32'd0);

    // Fill to capacity with threshold checks, overflow, drain, underflow.
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
      chk("thr_af", 32'(af), 32'((i + 1) >= AFT));
      chk("thr_ae", 32'(ae), 32'((i + 1) <= AET));
    end
    chk("full_wfull", 32'(wfull), 32'd1);
    cyc(1'b1, 16'h0077, 1'b0, 1'b0, 1'b0);
    chk("full_overflow", 32'(overflow), 32'd1);
    idle(2);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_rvalid", 32'(rvalid), 32'd1);
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("extra_ren_underflow", 32'(underflow), 32'd1);
    chk("extra_ren_rvalid",    32'(rvalid),    32'd0);

    // Sustained write+pop with three words held: gapless, count constant, pointers wrap.
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0, 1'b0);
    idle(3);
    for (int i = 0; i < 40; i++) begin
      chk("stream_rvalid", 32'(rvalid), 32'd1);
      cyc(1'b1, 16'(16'h0200 + i), 1'b1, 1'b0, 1'b0);
      chk("stream_count", 32'(count), 32'd3);
    end
    for (int k = 0; k < 20 && vis_m > 0; k++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("stream_drained", 32'(count), 32'd0);

    // Clear with a simultaneous write and pop: clear wins.
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'(16'h0300 + i), 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("pre_clr_count",  32'(count),  32'd5);
    chk("pre_clr_rvalid", 32'(rvalid), 32'd1);
    rst_clr(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("post_clr_rvalid", 32'(rvalid), 32'd0);
    end

`ifdef SYN_FIFO_PKT_EN
    // Packet mode: hidden until commit, drop discards, drop beats commit.
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'(16'h0400 + i), 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("pkt_hidden_rvalid", 32'(rvalid),  32'd0);
    chk("pkt_cnt3",          32'(pkt_cnt), 32'd3);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("pkt_c0_rvalid", 32'(rvalid), 32'd0);
    idle(1);
    chk("pkt_c1_rvalid", 32'(rvalid), 32'd0);
    idle(1);
    chk("pkt_c2_rvalid", 32'(rvalid), 32'd1);
    for (int k = 0; k < 20 && vis_m > 0; k++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 16'h0501, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0502, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("pkt_drop_cnt", 32'(pkt_cnt), 32'd0);
    cyc(1'b1, 16'h0503, 1'b0, 1'b1, 1'b1);
    idle(4);
    chk("pkt_drop_rvalid", 32'(rvalid), 32'd0);
    cyc(1'b1, 16'h0666, 1'b0, 1'b1, 1'b0);
    idle(2);
    chk("pkt_after_drop_rvalid", 32'(rvalid), 32'd1);
    chk("pkt_after_drop_rdata",  32'(rdata),  32'h0666);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
`endif

    idle(2);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire
